// File: rtl/char_motion_if.sv
// Frame strobe, key inputs and sprite placement outputs of the character motion block.
interface char_motion_if;
    logic       frame_clk;
    logic       move_left;
    logic       move_right;
    logic       jump;
    logic [9:0] sprite_x_start;
    logic [9:0] sprite_y_start;
    logic       facing_left;
    logic       airborne;

    modport master (
        output frame_clk, move_left, move_right, jump,
        input  sprite_x_start, sprite_y_start, facing_left, airborne
    );

    modport slave (
        input  frame_clk, move_left, move_right, jump,
        output sprite_x_start, sprite_y_start, facing_left, airborne
    );
endinterface

// File: rtl/char_motion.sv
// Per-frame character motion: clamped horizontal walking plus a single-jump gravity arc.
module char_motion #(
    parameter int X_START  = 40,
    parameter int GROUND_Y = 400,
    parameter int SPRITE_W = 41,
    parameter int SCREEN_W = 640,
    parameter int X_STEP   = 2,
    parameter int JUMP_VEL = 12,
    parameter int GRAVITY  = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    char_motion_if.slave  bus
);

    typedef enum logic {GROUND = 1'b0, AIR = 1'b1} state_e;

    localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - SPRITE_W);
    localparam logic signed [10:0] Y_GND = 11'(GROUND_Y);

    state_e            state_q, state_d;
    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic signed [7:0] vel_q, vel_d;
    logic              facing_q, facing_d;
    logic              frame_q;
    logic              armed_q;
    logic              tick;
    logic              go_left, go_right;
    logic signed [10:0] x_sum, y_sum;

    // armed_q blocks a tick from a frame_clk that was already high across reset release.
    always_comb begin
        tick = bus.frame_clk & ~frame_q & armed_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_q  <= 1'b0;
            armed_q  <= ~bus.frame_clk;
            state_q  <= GROUND;
            x_q      <= 10'(X_START);
            y_q      <= 10'(GROUND_Y);
            vel_q    <= '0;
            facing_q <= 1'b0;
        end else begin
            frame_q <= bus.frame_clk;
            armed_q <= armed_q | ~bus.frame_clk;
            if (tick) begin
                state_q  <= state_d;
                x_q      <= x_d;
                y_q      <= y_d;
                vel_q    <= vel_d;
                facing_q <= facing_d;
            end
        end
    end

    always_comb begin
        go_left  = bus.move_left & ~bus.move_right;
        go_right = bus.move_right & ~bus.move_left;

        x_sum    = $signed({1'b0, x_q});
        facing_d = facing_q;
        if (go_left) begin
            x_sum    = x_sum - 11'(X_STEP);
            facing_d = 1'b1;
        end else if (go_right) begin
            x_sum    = x_sum + 11'(X_STEP);
            facing_d = 1'b0;
        end

        if (x_sum < 0)          x_d = '0;
        else if (x_sum > X_MAX) x_d = X_MAX[9:0];
        else                    x_d = x_sum[9:0];

        y_sum   = $signed({1'b0, y_q}) + $signed({{3{vel_q[7]}}, vel_q});
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;

        case (state_q)
            GROUND: begin
                y_d   = 10'(GROUND_Y);
                vel_d = '0;
                if (bus.jump) begin
                    vel_d   = -8'(JUMP_VEL);
                    state_d = AIR;
                end
            end
            AIR: begin
                if (y_sum >= Y_GND) begin
                    y_d     = 10'(GROUND_Y);
                    vel_d   = '0;
                    state_d = GROUND;
                end else if (y_sum < 0) begin
                    y_d   = '0;
                    vel_d = '0;
                end else begin
                    y_d   = y_sum[9:0];
                    vel_d = vel_q + 8'(GRAVITY);
                end
            end
            default: state_d = GROUND;
        endcase
    end

    always_comb begin
        bus.sprite_x_start = x_q;
        bus.sprite_y_start = y_q;
        bus.facing_left    = facing_q;
        bus.airborne       = (state_q == AIR);
    end

endmodule

// File: tb/tb_char_motion.sv
// Self-checking bench for char_motion: directed scenarios plus randomized keys against a per-frame model.
module tb_char_motion;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    char_motion_if bus();

    char_motion dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference position/motion, advanced once per frame tick.
    int mx, my, mvel;
    bit mair, mface;

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        n_tests++;
        if (got !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".x"},      32'(bus.sprite_x_start), mx);
        check_eq({tag, ".y"},      32'(bus.sprite_y_start), my);
        check_eq({tag, ".facing"}, 32'(bus.facing_left),    int'(mface));
        check_eq({tag, ".air"},    32'(bus.airborne),       int'(mair));
    endtask

    task automatic model_reset();
        mx = 40; my = 400; mvel = 0; mair = 0; mface = 0;
    endtask

    task automatic model_step(input bit l, input bit r, input bit j);
        int yn;
        if (l && !r) begin
            mx    = (mx - 2 < 0) ? 0 : mx - 2;
            mface = 1;
        end else if (r && !l) begin
            mx    = (mx + 2 > 599) ? 599 : mx + 2;
            mface = 0;
        end
        if (!mair) begin
            if (j) begin
                mvel = -12;
                mair = 1;
            end
        end else begin
            yn = my + mvel;
            if (yn >= 400) begin
                my = 400; mvel = 0; mair = 0;
            end else if (yn < 0) begin
                my = 0; mvel = 0;
            end else begin
                my = yn; mvel = mvel + 1;
            end
        end
    endtask

    task automatic noise();
        bus.move_left  = 1'($urandom_range(0, 1));
        bus.move_right = 1'($urandom_range(0, 1));
        bus.jump       = 1'($urandom_range(0, 1));
    endtask

    // One frame: random-length low phase with key noise, a rising edge with the real keys, one held-high cycle.
    task automatic do_tick(input string tag, input bit l, input bit r, input bit j);
        bus.frame_clk = 1'b0;
        repeat ($urandom_range(1, 3)) begin
            noise();
            @(posedge Clk); #1;
        end
        check_all({tag, ".lo"});
        bus.move_left  = l;
        bus.move_right = r;
        bus.jump       = j;
        bus.frame_clk  = 1'b1;
        @(posedge Clk); #1;
        model_step(l, r, j);
        check_all(tag);
        noise();
        @(posedge Clk); #1;
        check_all({tag, ".hi"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int saved_x;

        Reset          = 1'b1;
        bus.frame_clk  = 1'b0;
        bus.move_left  = 1'b0;
        bus.move_right = 1'b0;
        bus.jump       = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        model_reset();
        check_all("reset");
        Reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            do_tick("walk", 0, 1, 0);
            check_eq("walk.const_x", 32'(bus.sprite_x_start), 42 + 2 * i);
        end

        for (int k = 0; k < 400 && mx < 599; k++) do_tick("wall_run", 0, 1, 0);
        do_tick("wall_back", 1, 0, 0);
        do_tick("wall_back", 1, 0, 0);
        check_eq("wall.start", 32'(bus.sprite_x_start), 595);
        for (int i = 0; i < 4; i++) begin
            do_tick("wall_push", 0, 1, 0);
            check_eq("wall.push_x", 32'(bus.sprite_x_start), (i == 0) ? 597 : 599);
        end
        do_tick("wall_left", 1, 0, 0);
        check_eq("wall.left_x", 32'(bus.sprite_x_start), 597);
        check_eq("wall.left_face", 32'(bus.facing_left), 1);

        do_tick("both_gnd", 1, 1, 0);
        check_eq("both_gnd.x", 32'(bus.sprite_x_start), 597);
        check_eq("both_gnd.face", 32'(bus.facing_left), 1);

        do_tick("launch", 0, 0, 1);
        check_eq("launch.y", 32'(bus.sprite_y_start), 400);
        check_eq("launch.air", 32'(bus.airborne), 1);
        for (int t = 1; t <= 25; t++) begin
            do_tick("arc", (t == 5), (t == 5), (t == 8));
            if (t == 1)  check_eq("arc.t1", 32'(bus.sprite_y_start), 388);
            if (t == 2)  check_eq("arc.t2", 32'(bus.sprite_y_start), 377);
            if (t == 3)  check_eq("arc.t3", 32'(bus.sprite_y_start), 367);
            if (t == 5)  check_eq("both_air.x", 32'(bus.sprite_x_start), 597);
            if (t == 12) check_eq("arc.peak", 32'(bus.sprite_y_start), 322);
            if (t == 24) check_eq("arc.t24_air", 32'(bus.airborne), 1);
            if (t == 25) begin
                check_eq("arc.land_y", 32'(bus.sprite_y_start), 400);
                check_eq("arc.land_air", 32'(bus.airborne), 0);
            end
        end

        do_tick("relaunch", 0, 0, 1);
        for (int t = 1; t <= 25; t++) do_tick("hold_land", 0, 0, 1);
        check_eq("hold_land.air", 32'(bus.airborne), 0);
        do_tick("hold_next", 0, 0, 1);
        check_eq("hold_next.air", 32'(bus.airborne), 1);
        for (int t = 1; t <= 12; t++) do_tick("to_peak", 0, 0, 0);
        check_eq("to_peak.y", 32'(bus.sprite_y_start), 322);

        bus.frame_clk = 1'b0;
        @(posedge Clk); #1;
        bus.move_left  = 1'b0;
        bus.move_right = 1'b1;
        bus.jump       = 1'b0;
        bus.frame_clk  = 1'b1;
        Reset          = 1'b1;
        @(posedge Clk); #1;
        model_reset();
        check_all("rst_mid");
        check_eq("rst_mid.x", 32'(bus.sprite_x_start), 40);
        check_eq("rst_mid.y", 32'(bus.sprite_y_start), 400);
        Reset = 1'b0;
        repeat (5) begin
            @(posedge Clk); #1;
            check_eq("rst_held_frame.x", 32'(bus.sprite_x_start), 40);
        end
        do_tick("rst_retick", 0, 1, 0);
        check_eq("rst_retick.x", 32'(bus.sprite_x_start), 42);

        saved_x = mx;
        bus.frame_clk = 1'b0;
        bus.move_right = 1'b1;
        bus.move_left  = 1'b0;
        bus.jump       = 1'b0;
        @(posedge Clk); #1;
        bus.frame_clk = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        model_step(0, 1, 0);
        check_eq("gate.one_step", 32'(bus.sprite_x_start), saved_x + 2);
        check_all("gate");

        bus.frame_clk = 1'b0;
        bus.jump = 1'b0;
        @(posedge Clk); #1;
        bus.jump = 1'b1;
        @(posedge Clk); #1;
        bus.jump = 1'b0;
        @(posedge Clk); #1;
        check_eq("pulse.no_launch_now", 32'(bus.airborne), 0);
        do_tick("pulse", 0, 0, 0);
        check_eq("pulse.no_launch", 32'(bus.airborne), 0);

        for (int i = 0; i < 300; i++) begin
            do_tick("rand",
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
